flex_stp_rx: RTL

FLEX_STP_RX -- requirements
Module: flex_stp_rx

---
 rtl/flex_stp_rx.sv | 111 +++++++++++
 1 files changed

// File: rtl/flex_stp_rx.sv
// Serial-to-parallel receiver with a one-word holding register, ack handshake and sticky overrun.
// Define FLEX_STP_PARITY_EN to expect a trailing even-parity bit per word and expose parity_error.
module flex_stp_rx #(
    parameter int NUM_BITS  = 8,
    parameter int SHIFT_MSB = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    input  logic                clear,
    input  logic                data_ack,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic                data_valid,
    output logic                overrun
`ifdef FLEX_STP_PARITY_EN
    ,
    output logic                parity_error
`endif
);

`ifdef FLEX_STP_PARITY_EN
    localparam int FRAME = NUM_BITS + 1;
`else
    localparam int FRAME = NUM_BITS;
`endif
    localparam int CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    logic [CNT_W-1:0]    bit_cnt;
    logic [NUM_BITS-1:0] shift_reg;
    logic [NUM_BITS-1:0] shifted;
    logic [NUM_BITS-1:0] new_word;
    logic                new_perr;
    logic                shift_data;
    logic                word_done;

    always_comb begin
        if (SHIFT_MSB != 0) begin
            shifted = {shift_reg[NUM_BITS-2:0], serial_in};
        end else begin
            shifted = {serial_in, shift_reg[NUM_BITS-1:1]};
        end
    end

    assign word_done = shift_enable && (bit_cnt == LAST);

`ifdef FLEX_STP_PARITY_EN
    // The final shift of a frame is the parity bit; it never enters the data register.
    assign shift_data = shift_enable && (bit_cnt != LAST);
    assign new_word   = shift_reg;
    assign new_perr   = ^{shift_reg, serial_in};
`else
    assign shift_data = shift_enable;
    assign new_word   = shifted;
    assign new_perr   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (clear) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (shift_enable) begin
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (shift_data) begin
                shift_reg <= shifted;
            end
        end
    end

    logic perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parallel_out <= '0;
            data_valid   <= 1'b0;
            overrun      <= 1'b0;
            perr_q       <= 1'b0;
        end else if (clear) begin
            parallel_out <= '0;
            data_valid   <= 1'b0;
            overrun      <= 1'b0;
            perr_q       <= 1'b0;
        end else if (word_done) begin
            // A completed word may replace the held one only if the consumer takes it this edge.
            if (!data_valid || data_ack) begin
                parallel_out <= new_word;
                data_valid   <= 1'b1;
                perr_q       <= new_perr;
            end else begin
                overrun <= 1'b1;
            end
        end else if (data_ack && data_valid) begin
            data_valid <= 1'b0;
            perr_q     <= 1'b0;
        end
    end

`ifdef FLEX_STP_PARITY_EN
    assign parity_error = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q ^ new_perr;
`endif

endmodule
